// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch sequencer: FSM state encoding,
// opcode constants and opcode extraction.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [3:0] OPC_HALT = 4'b0000;
    localparam logic [3:0] OPC_ADDI = 4'b0001;
    localparam logic [3:0] OPC_OUT  = 4'b1111;

    // Opcode is the top nibble of an inst_w-bit word (inst_w <= 32).
    function automatic logic [3:0] opcode_of(input logic [31:0] inst, input int inst_w);
        return inst[inst_w-1 -: 4];
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Fetch program counter: restart beats branch load beats increment;
// increment wraps naturally modulo 2^ADDR_W.
module pc_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (restart) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter / fetch controller feeding the execute stage over ir_valid/ir_ready.
// Optional single-step input enabled by defining FETCH_SINGLE_STEP_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int INST_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              restart,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    state_t state;
    logic   single;
    logic   step_go;
    logic   is_halt;
    logic   accept;
    logic   take_branch;
    logic   fetch_now;
    logic   load_word;
    logic   halt_word;

`ifdef FETCH_SINGLE_STEP_EN
    assign step_go = step && !run;
`else
    assign step_go = 1'b0;
`endif

    // ir_valid is always set in HOLD, so accept needs only the ready side.
    always_comb begin
        is_halt     = (opcode_of(32'(rom_inst), INST_W) == OPC_HALT);
        accept      = (state == HOLD) && ir_ready;
        take_branch = accept && branch_taken;
        fetch_now   = ((state == FETCH) && (run || single)) ||
                      (accept && !branch_taken && run);
        load_word   = fetch_now && !is_halt;
        halt_word   = fetch_now && is_halt;
    end

    assign rom_addr = pc;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .load    (take_branch),
        .target  (branch_target),
        .inc     (load_word),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            single   <= 1'b0;
        end else if (restart) begin
            state    <= IDLE;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            single   <= 1'b0;
        end else begin
            if (load_word) begin
                ir       <= rom_inst;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (run) begin
                        state  <= FETCH;
                        single <= 1'b0;
                    end else if (step_go) begin
                        state  <= FETCH;
                        single <= 1'b1;
                    end
                end
                FETCH: begin
                    single <= 1'b0;
                    if (halt_word) begin
                        ir_valid <= 1'b0;
                        halted   <= 1'b1;
                        state    <= HALTED;
                    end else if (load_word) begin
                        state <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        if (halt_word) begin
                            ir_valid <= 1'b0;
                            halted   <= 1'b1;
                            state    <= HALTED;
                        end else if (!load_word) begin
                            // Branch bubble or run dropped: nothing replaces the delivered word.
                            ir_valid <= 1'b0;
                            state    <= (take_branch && run) ? FETCH : IDLE;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios push expected deliveries,
// a monitor pops and compares on every ir_valid & ir_ready cycle.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        restart;
    logic        ir_ready;
    logic        branch_taken;
    logic [2:0]  branch_target;
    logic [2:0]  rom_addr;
    logic [15:0] rom_inst;
    logic [15:0] ir;
    logic [2:0]  ir_pc;
    logic        ir_valid;
    logic        halted;
    logic [2:0]  pc;
`ifdef FETCH_SINGLE_STEP_EN
    logic        step;
`endif

    logic [15:0] rom [8];
    assign rom_inst = rom[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] exp_q [$];
    logic [18:0] exp_e;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W   (3),
        .INST_W   (16),
        .RESET_PC (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .restart       (restart),
`ifdef FETCH_SINGLE_STEP_EN
        .step          (step),
`endif
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted),
        .pc            (pc)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [15:0] word);
        exp_q.push_back({3'(addr), word});
    endtask

    task automatic do_reset();
        run           = 1'b0;
        restart       = 1'b0;
        ir_ready      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 3'd0;
`ifdef FETCH_SINGLE_STEP_EN
        step          = 1'b0;
`endif
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick(1);
    endtask

    // Monitor: every accepted handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ir_valid && ir_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_delivery: got ir_pc=%0d ir=0x%h, expected no delivery",
                         ir_pc, ir);
            end else begin
                exp_e = exp_q.pop_front();
                chk("deliver_ir_pc", int'(ir_pc), int'(exp_e[18:16]));
                chk("deliver_ir", int'(ir), int'(exp_e[15:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and back-to-back stream with PC wrap
        for (int i = 0; i < 8; i++) rom[i] = (i == 0) ? 16'h1C0A : 16'hFC00;
        rst_n = 1'b0;
        run = 1'b0; restart = 1'b0; ir_ready = 1'b0; branch_taken = 1'b0; branch_target = 3'd0;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b0;
`endif
        #12;
        chk("reset_ir_valid", int'(ir_valid), 0);
        chk("reset_ir", int'(ir), 0);
        chk("reset_ir_pc", int'(ir_pc), 0);
        chk("reset_pc", int'(pc), 0);
        chk("reset_halted", int'(halted), 0);
        do_reset();
        push(0, 16'h1C0A);
        for (int i = 1; i < 8; i++) push(i, 16'hFC00);
        push(0, 16'h1C0A);
        ir_ready = 1'b1;
        run = 1'b1;
        tick(10);
        run = 1'b0;
        tick(3);
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_idle_valid", int'(ir_valid), 0);
        chk("stream_pc_after", int'(pc), 1);

        // Five-cycle stall at ir_pc=2
        for (int i = 0; i < 8; i++) rom[i] = 16'h1000 + 16'(i);
        do_reset();
        for (int i = 0; i < 6; i++) push(i, 16'h1000 + 16'(i));
        ir_ready = 1'b1;
        run = 1'b1;
        tick(4);
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_ir_pc", int'(ir_pc), 2);
            chk("stall_ir", int'(ir), 16'h1002);
            chk("stall_valid", int'(ir_valid), 1);
            chk("stall_pc", int'(pc), 3);
        end
        ir_ready = 1'b1;
        tick(3);
        run = 1'b0;
        tick(3);
        chk("stall_drained", exp_q.size(), 0);

        // Stray branch ignored, then taken branch to 5 with one bubble
        for (int i = 0; i < 8; i++) rom[i] = 16'h2000 + 16'(i);
        do_reset();
        ir_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 3'd6;
        tick(2);
        chk("stray_branch_pc", int'(pc), 0);
        chk("stray_branch_valid", int'(ir_valid), 0);
        branch_taken = 1'b0;
        push(0, 16'h2000); push(1, 16'h2001); push(5, 16'h2005); push(6, 16'h2006);
        run = 1'b1;
        tick(3);
        chk("branch_pre_ir_pc", int'(ir_pc), 1);
        branch_taken = 1'b1;
        branch_target = 3'd5;
        tick(1);
        branch_taken = 1'b0;
        branch_target = 3'd0;
        chk("branch_bubble_valid", int'(ir_valid), 0);
        chk("branch_bubble_pc", int'(pc), 5);
        tick(1);
        chk("branch_target_valid", int'(ir_valid), 1);
        chk("branch_target_ir_pc", int'(ir_pc), 5);
        tick(1);
        run = 1'b0;
        tick(3);
        chk("branch_drained", exp_q.size(), 0);

        // HALT at address 3, then restart
        for (int i = 0; i < 8; i++) rom[i] = (i == 3) ? 16'h0000 : 16'h3000 + 16'(i);
        do_reset();
        push(0, 16'h3000); push(1, 16'h3001); push(2, 16'h3002);
        ir_ready = 1'b1;
        run = 1'b1;
        tick(5);
        chk("halt_halted", int'(halted), 1);
        chk("halt_valid", int'(ir_valid), 0);
        chk("halt_pc", int'(pc), 3);
        tick(4);
        chk("halt_stays", int'(halted), 1);
        chk("halt_stays_valid", int'(ir_valid), 0);
        chk("halt_drained", exp_q.size(), 0);
        push(0, 16'h3000); push(1, 16'h3001); push(2, 16'h3002);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_halted", int'(halted), 0);
        chk("restart_pc", int'(pc), 0);
        chk("restart_valid", int'(ir_valid), 0);
        begin
            int cyc = 0;
            while (!halted && cyc < 20) begin
                tick(1);
                cyc++;
            end
        end
        chk("rehalt_halted", int'(halted), 1);
        chk("rehalt_drained", exp_q.size(), 0);

        // Asynchronous reset while an instruction is stalled
        for (int i = 0; i < 8; i++) rom[i] = 16'h4000 + 16'(i);
        do_reset();
        run = 1'b1;
        tick(4);
        chk("areset_pre_valid", int'(ir_valid), 1);
        chk("areset_pre_ir", int'(ir), 16'h4000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", int'(ir_valid), 0);
        chk("areset_ir", int'(ir), 0);
        chk("areset_ir_pc", int'(ir_pc), 0);
        chk("areset_pc", int'(pc), 0);
        rst_n = 1'b1;
        push(0, 16'h4000); push(1, 16'h4001);
        ir_ready = 1'b1;
        tick(3);
        run = 1'b0;
        tick(3);
        chk("areset_drained", exp_q.size(), 0);

`ifdef FETCH_SINGLE_STEP_EN
        // Two single-step pulses with run low
        for (int i = 0; i < 8; i++) rom[i] = 16'h5000 + 16'(i);
        do_reset();
        ir_ready = 1'b1;
        push(0, 16'h5000);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(4);
        chk("step1_drained", exp_q.size(), 0);
        chk("step1_idle_valid", int'(ir_valid), 0);
        chk("step1_pc", int'(pc), 1);
        tick(3);
        chk("step_gap_pc", int'(pc), 1);
        push(1, 16'h5001);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(4);
        chk("step2_drained", exp_q.size(), 0);
        chk("step2_pc", int'(pc), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
